// File: rtl/zmips_muldiv.sv
// Iterative 32x32 multiply / divide unit: shift-add multiply, restoring divide,
// 32 iterations per operation with a fixed 34-cycle start-to-done latency.
module zmips_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dz
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [W-1:0]   acc_hi, acc_hi_nx, acc_lo, acc_lo_nx;
    logic [W-1:0]   opnd, opnd_nx, a_raw, a_raw_nx;
    logic           is_div, is_div_nx, b_zero, b_zero_nx;
    logic           neg_lo, neg_lo_nx, neg_hi, neg_hi_nx;
    logic           busy_nx, done_nx, dz_nx;
    logic [W-1:0]   hi_nx, lo_nx;

    logic           a_neg, b_neg, ge;
    logic [W-1:0]   mag_a, mag_b, trial;
    logic [W:0]     sum, addend, rem_sh;
    logic [2*W-1:0] prod, prod_s;

    // Datapath helpers shared by the iteration and completion steps
    always_comb begin
        a_neg  = op[0] & a[W-1];
        b_neg  = op[0] & b[W-1];
        mag_a  = a_neg ? -a : a;
        mag_b  = b_neg ? -b : b;
        sum    = {1'b0, acc_hi} + {1'b0, opnd};
        addend = acc_lo[0] ? sum : {1'b0, acc_hi};
        rem_sh = {acc_hi, acc_lo[W-1]};
        ge     = rem_sh >= {1'b0, opnd};
        trial  = rem_sh[W-1:0] - opnd;
        prod   = {acc_hi, acc_lo};
        prod_s = neg_lo ? -prod : prod;
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        acc_hi_nx = acc_hi;
        acc_lo_nx = acc_lo;
        opnd_nx   = opnd;
        a_raw_nx  = a_raw;
        is_div_nx = is_div;
        b_zero_nx = b_zero;
        neg_lo_nx = neg_lo;
        neg_hi_nx = neg_hi;
        busy_nx   = busy;
        done_nx   = 1'b0;
        hi_nx     = hi;
        lo_nx     = lo;
        dz_nx     = dz;
        case (state)
            IDLE: begin
                // A start coinciding with the done pulse is deliberately dropped
                if (start && !done) begin
                    state_nx  = RUN;
                    cnt_nx    = '0;
                    busy_nx   = 1'b1;
                    is_div_nx = op[1];
                    b_zero_nx = (b == '0);
                    a_raw_nx  = a;
                    neg_lo_nx = a_neg ^ b_neg;
                    neg_hi_nx = a_neg;
                    acc_hi_nx = '0;
                    acc_lo_nx = op[1] ? mag_a : mag_b;
                    opnd_nx   = op[1] ? mag_b : mag_a;
                end
            end
            RUN: begin
                cnt_nx = cnt + CW'(1);
                if (is_div) begin
                    acc_hi_nx = ge ? trial : rem_sh[W-1:0];
                    acc_lo_nx = {acc_lo[W-2:0], ge};
                end else begin
                    acc_hi_nx = addend[W:1];
                    acc_lo_nx = {addend[0], acc_lo[W-1:1]};
                end
                if (cnt == CW'(W - 1)) state_nx = FIN;
            end
            FIN: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
                done_nx  = 1'b1;
                dz_nx    = is_div & b_zero;
                if (!is_div) begin
                    hi_nx = prod_s[2*W-1:W];
                    lo_nx = prod_s[W-1:0];
                end else if (b_zero) begin
                    hi_nx = a_raw;
                    lo_nx = '1;
                end else begin
                    hi_nx = neg_hi ? -acc_hi : acc_hi;
                    lo_nx = neg_lo ? -acc_lo : acc_lo;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            a_raw  <= '0;
            is_div <= 1'b0;
            b_zero <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            dz     <= 1'b0;
        end else begin
            cnt    <= cnt_nx;
            acc_hi <= acc_hi_nx;
            acc_lo <= acc_lo_nx;
            opnd   <= opnd_nx;
            a_raw  <= a_raw_nx;
            is_div <= is_div_nx;
            b_zero <= b_zero_nx;
            neg_lo <= neg_lo_nx;
            neg_hi <= neg_hi_nx;
            busy   <= busy_nx;
            done   <= done_nx;
            hi     <= hi_nx;
            lo     <= lo_nx;
            dz     <= dz_nx;
        end
    end
endmodule

// File: doc/zmips_muldiv.md
ZMIPS_MULDIV -- requirements
Module: zmips_muldiv

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port a, input, 32 bits: operand A (multiplicand or dividend).
REQ-004 SHALL have port b, input, 32 bits: operand B (multiplier or divisor).
REQ-005 SHALL have port op, input, 2 bits: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port start, input, 1 bit: request; sampled only while busy=0.
REQ-007 SHALL have port busy, output, 1 bit: operation in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when hi/lo are updated.
REQ-009 SHALL have port hi, output, 32 bits: upper product or remainder.
REQ-010 SHALL have port lo, output, 32 bits: lower product or quotient.
REQ-011 SHALL have port dz, output, 1 bit: the last completed divide had b=0; valid from done until the next done.

Function
REQ-012 SHALL implement the states IDLE, RUN and FIN.
REQ-013 SHALL, in IDLE with start=1, capture a, b and op, go to RUN and assert busy from the next cycle.
REQ-014 SHALL take exactly 32 cycles in RUN, one iteration per cycle, using a 6-bit iteration counter.
REQ-015 SHALL, in FIN, write hi/lo, pulse done for exactly one cycle, deassert busy, and return to IDLE.
REQ-016 SHALL give a fixed latency: start sampled in cycle N gives done=1 in cycle N+34, and busy=1 in cycles N+1 through N+33.
REQ-017 SHALL ignore start while busy=1: no queueing and no change to captured operands.
REQ-018 SHALL allow back-to-back use: start=1 in the same cycle as done=1 is not accepted; start in the cycle after done is accepted.
REQ-019 SHALL hold hi/lo constant except in the FIN cycle; outputs reflect only the last completed operation.
REQ-020 SHALL compute MULTU as the 64-bit unsigned product {hi,lo} = a*b using shift-add.
REQ-021 SHALL compute MULT as the 64-bit two's-complement product: operands are made non-negative first, and the 64-bit result is negated when the operand signs differ.
REQ-022 SHALL compute DIVU with restoring division: lo = a/b and hi = a mod b, unsigned.
REQ-023 SHALL compute DIV with the quotient truncated toward zero and the remainder taking the sign of the dividend.
REQ-024 SHALL handle DIV of 0x80000000 by 0xFFFFFFFF as lo=0x80000000, hi=0x00000000, dz=0.
REQ-025 SHALL handle divide by zero (b=0, DIV or DIVU) with the same 34-cycle latency: lo=0xFFFFFFFF, hi=a, dz=1.
REQ-026 SHALL clear dz on completion of any operation without a zero divisor, including multiplies.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, force state IDLE, busy=0, done=0, hi=0, lo=0, dz=0 and counter=0.
REQ-028 SHALL give rst priority over start and over an operation in progress: rst during RUN aborts it, and hi/lo/done do not update.
REQ-029 SHALL ignore start in a cycle where rst=1.

Verification
REQ-030 SHALL pass this test: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at N+34, hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 SHALL pass this test: MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
REQ-032 SHALL pass this test: DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=7 -> lo=14, hi=2.
REQ-033 SHALL pass this test: DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, dz=1; a following MULTU 2*3 -> lo=6, hi=0, dz=0.
REQ-034 SHALL pass this test: start held high continuously -> operations complete every 35 cycles; operands changed mid-RUN do not affect the result.
REQ-035 SHALL pass this test: rst pulsed at RUN cycle 10 -> next cycle busy=0, hi=lo=0, and no done pulse; a fresh start then completes normally.
